mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous memory between the CPU instruction-fetch

---
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction-fetch and data ports.
// Data wins by default; a starvation counter forces an inst grant after STARVE_MAX data wins.
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req_i,
  input  logic [AW-1:0] inst_addr_i,
  output logic [DW-1:0] inst_rdata_o,
  output logic          inst_ack_o,
  input  logic          data_req_i,
  input  logic          data_we_i,
  input  logic [3:0]    data_sel_i,
  input  logic [AW-1:0] data_addr_i,
  input  logic [DW-1:0] data_wdata_i,
  output logic [DW-1:0] data_rdata_o,
  output logic          data_ack_o,
  output logic          mem_ce_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_sel_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          stallreq_o
);

  localparam int unsigned LCW = 3;
  localparam int unsigned SCW = $clog2(STARVE_MAX + 1);
  localparam logic [LCW-1:0] LAT_LOAD   = LCW'(MEM_LAT - 1);
  localparam logic [SCW-1:0] STARVE_TOP = SCW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [LCW-1:0]  lat_cnt_q, lat_cnt_d;
  logic [SCW-1:0]  starve_cnt_q, starve_cnt_d;
  logic            gnt_data_q, gnt_data_d;
  logic            mem_ce_q, mem_ce_d;
  logic            mem_we_q, mem_we_d;
  logic [3:0]      mem_sel_q, mem_sel_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            inst_ack_q, inst_ack_d;
  logic            data_ack_q, data_ack_d;
  logic [DW-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DW-1:0]   data_rdata_q, data_rdata_d;
  logic            inst_eff, data_eff, pick_data, pick_inst;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      gnt_data_q   <= 1'b0;
      mem_ce_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_sel_q    <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_ack_q   <= 1'b0;
      data_ack_q   <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      gnt_data_q   <= gnt_data_d;
      mem_ce_q     <= mem_ce_d;
      mem_we_q     <= mem_we_d;
      mem_sel_q    <= mem_sel_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_ack_q   <= inst_ack_d;
      data_ack_q   <= data_ack_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // Next state, arbitration and memory-side outputs
  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    gnt_data_d   = gnt_data_q;
    mem_ce_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_sel_d    = '0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    inst_ack_d   = 1'b0;
    data_ack_d   = 1'b0;
    inst_rdata_d = '0;
    data_rdata_d = '0;

    // The port being acked this cycle may still hold req; it must not win again.
    inst_eff  = inst_req_i & ~((state_q == S_DONE) & ~gnt_data_q);
    data_eff  = data_req_i & ~((state_q == S_DONE) & gnt_data_q);
    pick_data = data_eff & ~(inst_eff & (starve_cnt_q == STARVE_TOP));
    pick_inst = inst_eff & ~pick_data;

    case (state_q)
      S_ACCESS: begin
        if (lat_cnt_q == '0) begin
          state_d = S_DONE;
          if (gnt_data_q) begin
            data_ack_d   = 1'b1;
            data_rdata_d = mem_we_q ? '0 : mem_rdata_i;
          end else begin
            inst_ack_d   = 1'b1;
            inst_rdata_d = mem_rdata_i;
          end
        end else begin
          lat_cnt_d   = lat_cnt_q - LCW'(1);
          mem_ce_d    = 1'b1;
          mem_we_d    = mem_we_q;
          mem_sel_d   = mem_sel_q;
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = mem_wdata_q;
        end
      end
      default: begin
        // IDLE and DONE both arbitrate so a waiting port issues without a bubble
        state_d = S_IDLE;
        if (pick_data) begin
          state_d     = S_ACCESS;
          lat_cnt_d   = LAT_LOAD;
          gnt_data_d  = 1'b1;
          mem_ce_d    = 1'b1;
          mem_we_d    = data_we_i;
          mem_sel_d   = data_sel_i;
          mem_addr_d  = data_addr_i;
          mem_wdata_d = data_wdata_i;
          if (inst_eff && (starve_cnt_q != STARVE_TOP)) begin
            starve_cnt_d = starve_cnt_q + SCW'(1);
          end
        end else if (pick_inst) begin
          state_d      = S_ACCESS;
          lat_cnt_d    = LAT_LOAD;
          gnt_data_d   = 1'b0;
          starve_cnt_d = '0;
          mem_ce_d     = 1'b1;
          mem_sel_d    = 4'hF;
          mem_addr_d   = inst_addr_i;
        end
      end
    endcase
  end

  assign inst_rdata_o = inst_rdata_q;
  assign inst_ack_o   = inst_ack_q;
  assign data_rdata_o = data_rdata_q;
  assign data_ack_o   = data_ack_q;
  assign mem_ce_o     = mem_ce_q;
  assign mem_we_o     = mem_we_q;
  assign mem_sel_o    = mem_sel_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign stallreq_o   = (inst_req_i & ~inst_ack_q) | (data_req_i & ~data_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timing reference model checked every cycle,
// directed scenarios on a MEM_LAT=1/STARVE_MAX=2 instance and a MEM_LAT=3 instance.
module tb_mem_port_arbiter;
  localparam int LAT  = 1;
  localparam int SMAX = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inst_req, inst_ack, data_req, data_we, data_ack;
  logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
  logic [3:0]  data_sel, mem_sel;
  logic        mem_ce, mem_we, stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] env_mem [64];

  logic        d3_req, d3_ack, i3_ack, m3_ce, m3_we, s3_stall;
  logic [31:0] d3_addr, d3_rdata, i3_rdata, m3_addr, m3_wdata, r3_rdata;
  logic [3:0]  m3_sel;

  assign mem_rdata = env_mem[mem_addr[7:2]];

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_rdata_o(inst_rdata), .inst_ack_o(inst_ack),
    .data_req_i(data_req), .data_we_i(data_we), .data_sel_i(data_sel), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .data_ack_o(data_ack),
    .mem_ce_o(mem_ce), .mem_we_o(mem_we), .mem_sel_o(mem_sel), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .stallreq_o(stall)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .inst_req_i(1'b0), .inst_addr_i(32'h0), .inst_rdata_o(i3_rdata), .inst_ack_o(i3_ack),
    .data_req_i(d3_req), .data_we_i(1'b0), .data_sel_i(4'hF), .data_addr_i(d3_addr),
    .data_wdata_i(32'h0), .data_rdata_o(d3_rdata), .data_ack_o(d3_ack),
    .mem_ce_o(m3_ce), .mem_we_o(m3_we), .mem_sel_o(m3_sel), .mem_addr_o(m3_addr),
    .mem_wdata_o(m3_wdata), .mem_rdata_i(r3_rdata), .stallreq_o(s3_stall)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner 0=none 1=inst 2=data; m_t = cycles since grant
  int          m_own, m_t, m_starve;
  logic        m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [31:0] ref_mem [64];

  logic        o_inst_ack, o_data_ack, o_ce, o_we, o_stall;
  logic [3:0]  o_sel;
  logic [31:0] o_inst_rdata, o_data_rdata;
  logic        o3_ce, o3_ack, o3_stall, o3_we;
  logic [31:0] o3_rdata, o3_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // One clock: check at negedge, then advance memory and model after posedge
  task automatic step();
    bit acc, dn, ireq, dreq;
    logic wr_en;
    logic [3:0] wr_sel;
    logic [31:0] wr_addr, wr_data;
    @(negedge clk);
    acc = (m_own != 0) && (m_t >= 1) && (m_t <= LAT);
    dn  = (m_own != 0) && (m_t == LAT + 1);
    o_inst_ack = inst_ack;  o_data_ack = data_ack;  o_ce = mem_ce;  o_we = mem_we;
    o_sel = mem_sel;  o_stall = stall;  o_inst_rdata = inst_rdata;  o_data_rdata = data_rdata;
    o3_ce = m3_ce;  o3_we = m3_we;  o3_ack = d3_ack;  o3_rdata = d3_rdata;
    o3_addr = m3_addr;  o3_stall = s3_stall;
    chk("mem_ce", 64'(mem_ce), 64'(acc));
    chk("mem_we", 64'(mem_we), 64'(acc && m_we));
    chk("mem_sel", 64'(mem_sel), 64'(acc ? m_sel : 4'h0));
    chk("mem_addr", 64'(mem_addr), 64'(acc ? m_addr : 32'h0));
    if (acc && m_own == 2) chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    chk("inst_ack", 64'(inst_ack), 64'(dn && m_own == 1));
    chk("data_ack", 64'(data_ack), 64'(dn && m_own == 2));
    if (dn && m_own == 1) chk("inst_rdata", 64'(inst_rdata), 64'(m_rdata));
    if (dn && m_own == 2) chk("data_rdata", 64'(data_rdata), 64'(m_rdata));
    chk("stallreq", 64'(stall),
        64'((inst_req && !(dn && m_own == 1)) || (data_req && !(dn && m_own == 2))));
    wr_en = mem_ce & mem_we;  wr_sel = mem_sel;  wr_addr = mem_addr;  wr_data = mem_wdata;
    @(posedge clk);
    if (wr_en) env_mem[wr_addr[7:2]] = merge(env_mem[wr_addr[7:2]], wr_data, wr_sel);
    if (acc && m_we) ref_mem[m_addr[7:2]] = merge(ref_mem[m_addr[7:2]], m_wdata, m_sel);
    if (rst) begin
      m_own = 0;  m_t = 0;  m_starve = 0;
    end else if (m_own != 0 && m_t <= LAT) begin
      if (m_t == LAT) m_rdata = (m_own == 2 && m_we) ? 32'h0 : ref_mem[m_addr[7:2]];
      m_t++;
    end else begin
      ireq = inst_req && (m_own != 1);
      dreq = data_req && (m_own != 2);
      if (dreq && !(ireq && m_starve == SMAX)) begin
        m_own = 2;  m_we = data_we;  m_sel = data_sel;  m_addr = data_addr;  m_wdata = data_wdata;
        if (ireq && m_starve < SMAX) m_starve++;
      end else if (ireq) begin
        m_own = 1;  m_we = 1'b0;  m_sel = 4'hF;  m_addr = inst_addr;  m_wdata = 32'h0;
        m_starve = 0;
      end else begin
        m_own = 0;
      end
      m_t = (m_own != 0) ? 1 : 0;
    end
    #1;
  endtask

  initial begin
    int k_ack, k_ack2, cnt, na;
    int seq [6];
    logic [31:0] seen, seen_sel;
    logic seen_stall;

    rst = 1'b1;  inst_req = 1'b0;  data_req = 1'b0;  data_we = 1'b0;  data_sel = 4'h0;
    inst_addr = 32'h0;  data_addr = 32'h0;  data_wdata = 32'h0;
    d3_req = 1'b0;  d3_addr = 32'h0;  r3_rdata = 32'h0;
    m_own = 0;  m_t = 0;  m_starve = 0;  m_we = 1'b0;  m_sel = 4'h0;
    m_addr = 32'h0;  m_wdata = 32'h0;  m_rdata = 32'h0;
    for (int i = 0; i < 64; i++) env_mem[i] = $urandom;
    env_mem[4]  = 32'h3401_1100;
    env_mem[32] = 32'h1122_3344;
    for (int i = 0; i < 64; i++) ref_mem[i] = env_mem[i];
    repeat (2) @(posedge clk);
    #1;
    step();
    chk("rst_m3_ce", 64'(o3_ce), 64'(0));
    chk("rst_d3_ack", 64'(o3_ack), 64'(0));
    rst = 1'b0;
    step();

    // T1: inst read, ack two cycles after request
    inst_req = 1'b1;  inst_addr = 32'h0000_0010;
    k_ack = -1;  seen = 32'h0;  seen_stall = 1'b1;  cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (o_ce) cnt++;
      if (o_inst_ack) begin
        k_ack = k;  seen = o_inst_rdata;  seen_stall = o_stall;  inst_req = 1'b0;
        break;
      end
    end
    chk("t1_ack_cycle", 64'(k_ack), 64'(2));
    chk("t1_rdata", 64'(seen), 64'(32'h3401_1100));
    chk("t1_stall_on_ack", 64'(seen_stall), 64'(0));
    chk("t1_ce_cycles", 64'(cnt), 64'(1));

    // T2: partial write then read back the merged word
    data_req = 1'b1;  data_we = 1'b1;  data_sel = 4'b0011;
    data_addr = 32'h80;  data_wdata = 32'hAABB_CCDD;
    k_ack = -1;  cnt = 0;  seen = 32'hFFFF_FFFF;  seen_sel = 32'h0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (o_we) begin cnt++;  seen_sel = 32'(o_sel); end
      if (o_data_ack) begin k_ack = k;  seen = o_data_rdata;  data_req = 1'b0;  break; end
    end
    chk("t2_we_cycles", 64'(cnt), 64'(1));
    chk("t2_we_sel", 64'(seen_sel), 64'(4'b0011));
    chk("t2_wr_rdata", 64'(seen), 64'(0));
    step();
    data_req = 1'b1;  data_we = 1'b0;  data_sel = 4'hF;
    k_ack = -1;  seen = 32'h0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (o_data_ack) begin k_ack = k;  seen = o_data_rdata;  data_req = 1'b0;  break; end
    end
    chk("t2_rd_ack_cycle", 64'(k_ack), 64'(2));
    chk("t2_rd_rdata", 64'(seen), 64'(32'h1122_CCDD));

    // T3: simultaneous requests, data first, inst issued straight from DONE
    data_req = 1'b1;  data_we = 1'b0;  inst_req = 1'b1;  inst_addr = 32'h10;
    k_ack = -1;  k_ack2 = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (o_data_ack) begin k_ack = k;  data_req = 1'b0; end
      if (o_inst_ack) begin k_ack2 = k;  inst_req = 1'b0;  break; end
    end
    chk("t3_data_ack_cycle", 64'(k_ack), 64'(2));
    chk("t3_inst_after_data", 64'(k_ack2 - k_ack), 64'(2));

    // T4: inst withdrawn during data DONE, data withdrawn during inst DONE -> D,D,I,D,D,I
    data_we = 1'b1;  data_sel = 4'hF;  data_addr = 32'h40;  inst_addr = 32'h14;
    data_req = 1'b1;  inst_req = 1'b1;  na = 0;
    for (int i = 0; i < 6; i++) seq[i] = 0;
    for (int k = 0; k < 60 && na < 6; k++) begin
      data_wdata = $urandom;
      step();
      if (o_inst_ack && na < 6) begin seq[na] = 1;  na++; end
      if (o_data_ack && na < 6) begin seq[na] = 2;  na++; end
      inst_req = !(o_ce && o_we);
      data_req = !(o_ce && !o_we);
    end
    for (int i = 0; i < 6; i++) chk($sformatf("t4_grant_%0d", i), 64'(seq[i]), 64'((i % 3 == 2) ? 1 : 2));
    inst_req = 1'b0;  data_req = 1'b0;
    repeat (2) step();

    // T5: reset during a write ACCESS aborts it; held request then completes
    data_req = 1'b1;  data_we = 1'b1;  data_sel = 4'hF;  data_addr = 32'h90;  data_wdata = 32'h5A5A_5A5A;
    step();
    rst = 1'b1;
    step();
    chk("t5_ce_before_rst", 64'(o_ce), 64'(1));
    rst = 1'b0;
    step();
    chk("t5_ce_after_rst", 64'(o_ce), 64'(0));
    chk("t5_we_after_rst", 64'(o_we), 64'(0));
    chk("t5_no_ack", 64'(o_data_ack), 64'(0));
    k_ack = -1;
    for (int k = 1; k < 8; k++) begin
      step();
      if (o_data_ack) begin k_ack = k;  data_req = 1'b0;  break; end
    end
    chk("t5_retry_ack", 64'(k_ack), 64'(2));
    step();

    // Random traffic with withdrawals and occasional resets
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      if (inst_req) begin
        if (o_inst_ack || $urandom_range(0, 15) == 0) inst_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        inst_req = 1'b1;  inst_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      end
      if (data_req) begin
        if (o_data_ack) data_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        data_req = 1'b1;  data_we = 1'($urandom_range(0, 1));  data_sel = 4'($urandom_range(0, 15));
        data_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};  data_wdata = $urandom;
      end
      step();
    end
    rst = 1'b0;  inst_req = 1'b0;  data_req = 1'b0;
    repeat (3) step();

    // T6: MEM_LAT=3 read, capture from the third ACCESS cycle
    d3_req = 1'b1;  d3_addr = 32'h44;
    k_ack = -1;  cnt = 0;  seen = 32'h0;  seen_stall = 1'b1;
    for (int k = 0; k < 10; k++) begin
      r3_rdata = 32'hC0DE_0000 + 32'(k);
      step();
      if (o3_ce) begin
        cnt++;
        chk("t6_addr", 64'(o3_addr), 64'(32'h44));
        chk("t6_we", 64'(o3_we), 64'(0));
      end
      if (o3_ack) begin
        k_ack = k;  seen = o3_rdata;  seen_stall = o3_stall;  d3_req = 1'b0;
        chk("t6_ce_on_ack", 64'(o3_ce), 64'(0));
        break;
      end
    end
    chk("t6_ce_cycles", 64'(cnt), 64'(3));
    chk("t6_ack_cycle", 64'(k_ack), 64'(4));
    chk("t6_rdata", 64'(seen), 64'(32'hC0DE_0003));
    chk("t6_stall_on_ack", 64'(seen_stall), 64'(0));
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
